// File: rtl/bht_pkg.sv
// Shared types, 2-bit counter encodings and saturating-counter helpers for the
// branch history table.
package bht_pkg;

   localparam int unsigned MAX_CNT_W = 16;

   typedef logic [MAX_CNT_W-1:0] cnt_word_t;

   // Classic 2-bit counter encodings
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Weakly-not-taken reset value: 2^(width-1) - 1
   function automatic cnt_word_t wnt_init(input int unsigned width);
      int unsigned v;
      v = (32'd1 << (width - 32'd1)) - 32'd1;
      return cnt_word_t'(v);
   endfunction

   function automatic cnt_word_t cnt_max(input int unsigned width);
      int unsigned v;
      v = (32'd1 << width) - 32'd1;
      return cnt_word_t'(v);
   endfunction

   // One saturating step: taken counts up to all-ones, not-taken down to zero.
   function automatic cnt_word_t cnt_next(input cnt_word_t cnt,
                                          input logic taken,
                                          input int unsigned width);
      cnt_word_t mx;
      mx = cnt_max(width);
      if (taken) begin
         return (cnt == mx) ? cnt : cnt + cnt_word_t'(1);
      end
      return (cnt == '0) ? cnt : cnt - cnt_word_t'(1);
   endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// Combinational saturating-counter step. The 2-bit build uses the explicit
// SNT/WNT/WT/ST transition table; wider counters use the generic helper.
module bht_sat_counter
   import bht_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic [CNT_W-1:0] state,
   input  logic             taken,
   output logic [CNT_W-1:0] next_state,
   output logic             predict
);

   assign predict = state[CNT_W-1];

   if (CNT_W == 2) begin : g_classic
      always_comb begin
         next_state = state;
         case (state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = state;
         endcase
      end
   end else begin : g_generic
      assign next_state = CNT_W'(cnt_next(cnt_word_t'(state), taken, CNT_W));
   end

endmodule

// File: rtl/bht_table.sv
// Branch history table: ENTRIES saturating counters, combinational lookup by PC,
// registered training from EX. Define BHT_GSHARE_EN to fold a global history into the index.
module bht_table
   import bht_pkg::*;
#(
   parameter  int unsigned ENTRIES = 64,
   parameter  int unsigned CNT_W   = 2,
   parameter  int unsigned PC_W    = 32,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [PC_W-1:0]  i_lookup_pc,
   output logic [IDX_W-1:0] o_lookup_idx,
   output logic             o_predict,
   output logic [CNT_W-1:0] o_state,
   input  logic             i_upd_valid,
   input  logic [IDX_W-1:0] i_upd_idx,
   input  logic             i_upd_taken,
   output logic [IDX_W-1:0] o_ghr
);

   localparam logic [CNT_W-1:0] WNT_INIT = CNT_W'(wnt_init(CNT_W));

   if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("bht_table: ENTRIES must be a power of two and at least 2");
   end
   if (CNT_W < 2 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
      $error("bht_table: CNT_W out of range");
   end
   if (PC_W < IDX_W + 2) begin : g_bad_pc_w
      $error("bht_table: PC_W too narrow for the index");
   end

   logic [CNT_W-1:0] cnt_q [ENTRIES];
   logic [CNT_W-1:0] cnt_d [ENTRIES];
   logic [IDX_W-1:0] base_idx;
   logic [IDX_W-1:0] lookup_idx;
   logic [CNT_W-1:0] upd_state;
   logic [CNT_W-1:0] upd_next;
   logic             upd_pred_unused;
   logic             unused_pc_lo;

   // Word-aligned fetch: the two low PC bits never reach the index.
   assign base_idx     = i_lookup_pc[IDX_W+1:2];
   assign unused_pc_lo = ^i_lookup_pc[1:0];

   if (PC_W > IDX_W + 2) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^i_lookup_pc[PC_W-1:IDX_W+2];
   end

`ifdef BHT_GSHARE_EN
   logic [IDX_W-1:0] ghr_q;
   logic [IDX_W-1:0] ghr_d;

   always_comb begin
      ghr_d = ghr_q;
      if (i_upd_valid) begin
         ghr_d = IDX_W'({ghr_q, i_upd_taken});
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   assign lookup_idx = base_idx ^ ghr_q;
   assign o_ghr      = ghr_q;
`else
   assign lookup_idx = base_idx;
   assign o_ghr      = '0;
`endif

   // Training path: the index from EX is used exactly as supplied.
   assign upd_state = cnt_q[i_upd_idx];

   bht_sat_counter #(
      .CNT_W (CNT_W)
   ) u_upd_ctr (
      .state      (upd_state),
      .taken      (i_upd_taken),
      .next_state (upd_next),
      .predict    (upd_pred_unused)
   );

   always_comb begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (i_upd_valid) begin
         cnt_d[i_upd_idx] = upd_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            cnt_q[i] <= WNT_INIT;
         end
      end else begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Lookup reads registered state only, so a same-cycle update is seen next cycle.
   assign o_lookup_idx = lookup_idx;
   assign o_state      = cnt_q[lookup_idx];
   assign o_predict    = o_state[CNT_W-1];

endmodule

// File: tb/tb_bht_table.sv
// Self-checking bench for bht_table: a 64x2 instance and a 16x3 instance driven
// from one directed sequence, checked against a reference model via a scoreboard queue.
module tb_bht_table;

   logic        clk;
   logic        rst;

   logic [31:0] a_pc;
   logic [5:0]  a_idx;
   logic        a_pred;
   logic [1:0]  a_state;
   logic        a_v;
   logic [5:0]  a_uidx;
   logic        a_t;
   logic [5:0]  a_ghr;

   logic [31:0] b_pc;
   logic [3:0]  b_idx;
   logic        b_pred;
   logic [2:0]  b_state;
   logic        b_v;
   logic [3:0]  b_uidx;
   logic        b_t;
   logic [3:0]  b_ghr;

   bht_table #(.ENTRIES(64), .CNT_W(2), .PC_W(32)) u_a (
      .i_clk(clk), .i_reset(rst), .i_lookup_pc(a_pc), .o_lookup_idx(a_idx),
      .o_predict(a_pred), .o_state(a_state), .i_upd_valid(a_v), .i_upd_idx(a_uidx),
      .i_upd_taken(a_t), .o_ghr(a_ghr)
   );

   bht_table #(.ENTRIES(16), .CNT_W(3), .PC_W(32)) u_b (
      .i_clk(clk), .i_reset(rst), .i_lookup_pc(b_pc), .o_lookup_idx(b_idx),
      .o_predict(b_pred), .o_state(b_state), .i_upd_valid(b_v), .i_upd_idx(b_uidx),
      .i_upd_taken(b_t), .o_ghr(b_ghr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t  sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   m_a[64];
   int   m_b[16];
   logic [5:0] g_a;
   logic [3:0] g_b;

   function automatic int sat(input int c, input bit t, input int w);
      int mx;
      mx = (1 << w) - 1;
      if (t) return (c < mx) ? c + 1 : c;
      return (c > 0) ? c - 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_a[i] = 1;
      for (int i = 0; i < 16; i++) m_b[i] = 3;
      g_a = '0;
      g_b = '0;
   endtask

   task automatic push(input string tag, input logic [31:0] e);
      sb_t s;
      s.tag = tag;
      s.exp = e;
      sb_q.push_back(s);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      sb_t s;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty observed=%0h required=queued_entry", obs);
      end else begin
         s = sb_q.pop_front();
         assert (obs === s.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", s.tag, obs, s.exp);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      push(tag, e);
      pop_cmp(obs);
   endtask

   function automatic logic [31:0] pc_a(input int idx);
      logic [5:0] i6;
      i6 = 6'(idx) ^ g_a;
      return {24'b0, i6, 2'b00};
   endfunction

   function automatic logic [31:0] pc_b(input int idx);
      logic [3:0] i4;
      i4 = 4'(idx) ^ g_b;
      return {26'b0, i4, 2'b00};
   endfunction

   task automatic step_a(input logic [31:0] pc, input bit v, input int idx, input bit t);
      logic [5:0] ei;
      @(negedge clk);
      a_pc = pc; a_v = v; a_uidx = 6'(idx); a_t = t; b_v = 1'b0;
      ei = pc[7:2] ^ g_a;
      push("a_idx", 32'(ei));
      push("a_state", m_a[ei]);
      push("a_pred", m_a[ei] >> 1);
      push("a_ghr", 32'(g_a));
      #2;
      pop_cmp(32'(a_idx));
      pop_cmp(32'(a_state));
      pop_cmp(32'(a_pred));
      pop_cmp(32'(a_ghr));
      if (v) begin
         m_a[idx] = sat(m_a[idx], t, 2);
`ifdef BHT_GSHARE_EN
         g_a = {g_a[4:0], t};
`endif
      end
   endtask

   task automatic step_b(input logic [31:0] pc, input bit v, input int idx, input bit t);
      logic [3:0] ei;
      @(negedge clk);
      b_pc = pc; b_v = v; b_uidx = 4'(idx); b_t = t; a_v = 1'b0;
      ei = pc[5:2] ^ g_b;
      push("b_idx", 32'(ei));
      push("b_state", m_b[ei]);
      push("b_pred", m_b[ei] >> 2);
      push("b_ghr", 32'(g_b));
      #2;
      pop_cmp(32'(b_idx));
      pop_cmp(32'(b_state));
      pop_cmp(32'(b_pred));
      pop_cmp(32'(b_ghr));
      if (v) begin
         m_b[idx] = sat(m_b[idx], t, 3);
`ifdef BHT_GSHARE_EN
         g_b = {g_b[2:0], t};
`endif
      end
   endtask

   initial begin
      int exp_s[4];
      int exp_p[4];
      int exp_b[5];
      logic [31:0] pc;

      rst = 1'b1;
      a_pc = '0; a_v = 1'b0; a_uidx = '0; a_t = 1'b0;
      b_pc = '0; b_v = 1'b0; b_uidx = '0; b_t = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state seen through several PCs
      step_a(32'h0, 0, 0, 0);
      chk("t1_state_pc0", 32'(a_state), 32'h1);
      chk("t1_pred_pc0", 32'(a_pred), 32'h0);
      step_a(32'h4, 0, 0, 0);
      chk("t1_state_pc4", 32'(a_state), 32'h1);
      step_a(32'hFC, 0, 0, 0);
      chk("t1_state_pcfc", 32'(a_state), 32'h1);
      chk("t1_ghr", 32'(a_ghr), 32'h0);
      step_b(32'h0, 0, 0, 0);
      chk("t5_reset_b", 32'(b_state), 32'h3);

      // Taken training of idx 5 with saturation at ST
      exp_s = '{1, 2, 3, 3};
      for (int k = 0; k < 4; k++) begin
         step_a(pc_a(5), 1, 5, 1);
         chk("t2_state", 32'(a_state), 32'(exp_s[k]));
      end
      step_a(pc_a(5), 0, 0, 0);
      chk("t2_state_st", 32'(a_state), 32'h3);
      chk("t2_pred", 32'(a_pred), 32'h1);

      // Not-taken training down to SNT
      exp_s = '{3, 2, 1, 0};
      exp_p = '{1, 1, 0, 0};
      for (int k = 0; k < 4; k++) begin
         step_a(pc_a(5), 1, 5, 0);
         chk("t3_state", 32'(a_state), 32'(exp_s[k]));
         chk("t3_pred", 32'(a_pred), 32'(exp_p[k]));
      end
      step_a(pc_a(5), 0, 0, 0);
      chk("t3_state_snt", 32'(a_state), 32'h0);

      // Same-cycle lookup and update: no bypass
      step_a(pc_a(5), 1, 5, 1);
      step_a(pc_a(5), 1, 5, 1);
      chk("t4_same_cycle", 32'(a_state), 32'h1);
      step_a(pc_a(5), 0, 0, 0);
      chk("t4_next_cycle", 32'(a_state), 32'h2);

      // 3-bit counters, 16 entries
      exp_b = '{3, 4, 5, 6, 7};
      for (int k = 0; k < 5; k++) begin
         step_b(pc_b(0), 1, 0, 1);
         chk("t5_state_b", 32'(b_state), 32'(exp_b[k]));
      end
      pc = 32'h40 ^ {26'b0, g_b, 2'b00};
      step_b(pc, 0, 0, 0);
      chk("t5_alias_idx", 32'(b_idx), 32'h0);
      chk("t5_sat_b", 32'(b_state), 32'h7);
      chk("t5_pred_b", 32'(b_pred), 32'h1);

`ifdef BHT_GSHARE_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step_a(32'h0, 1, 9, 1);
      step_a(32'h0, 1, 9, 1);
      step_a(32'h0, 1, 9, 0);
      step_a(32'h0, 0, 0, 0);
      chk("t6_ghr", 32'(a_ghr), 32'h6);
      chk("t6_idx", 32'(a_idx), 32'h6);
`endif

      // Randomised training against the model
      for (int k = 0; k < 300; k++) begin
         step_a($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
         if ((k % 4) == 0) begin
            step_b($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         end
      end

      // Asynchronous reset in the middle of an update cycle
      for (int k = 0; k < 3; k++) step_a(pc_a(5), 1, 5, 1);
      @(negedge clk);
      a_pc = pc_a(5); a_v = 1'b1; a_uidx = 6'd5; a_t = 1'b0;
      b_pc = '0; b_v = 1'b1; b_uidx = '0; b_t = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_state", 32'(a_state), 32'h1);
      chk("rst_async_ghr", 32'(a_ghr), 32'h0);
      chk("rst_async_b", 32'(b_state), 32'h3);
      chk("rst_async_bghr", 32'(b_ghr), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_state", 32'(a_state), 32'h1);
      @(negedge clk);
      rst = 1'b0; a_v = 1'b0; b_v = 1'b0;
      model_reset();
      for (int i = 0; i < 64; i++) step_a(32'(i) << 2, 0, 0, 0);
      for (int i = 0; i < 16; i++) step_b(32'(i) << 2, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
